// File: rtl/input_layer_pkg.sv
// Purpose : shared types and sizes for the input-layer window path.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package input_layer_pkg;

    localparam int PIX_W = 24;                   // one RGB pixel, 8 bits per channel
    localparam int WIN_K = 3;                    // window edge length
    localparam int WIN_W = PIX_W * WIN_K * WIN_K; // flattened 3x3 window

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/input_window_gen_if.sv
// Purpose : FIFO-pop side and window-output side of input_window_gen.
// Latency : n/a (wires only).
// Backpressure: out_ready from the consumer; fifo_count gates pops from the FIFO.
// Modports: master = window generator, slave = FIFO + downstream stage.
interface input_window_gen_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) ();
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    logic [input_layer_pkg::PIX_W-1:0] fifo_data;   // FIFO head, first-word fall-through
    logic [3:0]                        fifo_count;  // pixels available in the FIFO
    logic                              fifo_pop;    // consume head at this edge
    logic                              win_valid;
    logic                              out_ready;
    logic [input_layer_pkg::WIN_W-1:0] win_data;    // element k = 3*r + c at [24k+23:24k]
    logic [ROW_W-1:0]                  win_row;     // top-left row of window
    logic [COL_W-1:0]                  win_col;     // top-left column of window

    modport master (
        input  fifo_data, fifo_count, out_ready,
        output fifo_pop, win_valid, win_data, win_row, win_col
    );

    modport slave (
        output fifo_data, fifo_count, out_ready,
        input  fifo_pop, win_valid, win_data, win_row, win_col
    );
endinterface

// File: rtl/input_window_gen_line_buffer.sv
// Purpose : one image row of pixels, read and written at the same column index.
// Latency : read is combinational; write lands at the clock edge (old value read first).
// Backpressure: none; the caller only asserts we_i when a pixel is accepted.
// Ports   : clk/reset_n, we_i write enable, idx_i column, wdat_i pixel in, rdat_o pixel out.
module line_buffer
    import input_layer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [PIX_W-1:0]         wdat_i,
    output logic [PIX_W-1:0]         rdat_o
);

    logic [DEPTH-1:0][PIX_W-1:0] mem_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[idx_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[idx_i];

endmodule

// File: rtl/input_window_gen.sv
// Purpose : pops raster pixels from the input FIFO and emits every unpadded 3x3 window.
// Latency : window valid one cycle after the edge that pops its bottom-right pixel.
// Backpressure: a held window (valid && !out_ready) blocks pops; an empty FIFO stalls the scan.
// Ports   : clk, reset_n, start pulse, wif (FIFO + window bus), busy (RUN), done (1-cycle pulse).
module input_window_gen
    import input_layer_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input_window_gen_if.master    wif,
    output logic                  busy,
    output logic                  done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + 1);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             pix_cnt_q;
    logic [COL_W-1:0]             x_q;
    logic [ROW_W-1:0]             y_q;
    logic [WIN_K*WIN_K-1:0][PIX_W-1:0] win_q, win_shift;
    logic                         win_valid_q;
    logic [ROW_W-1:0]             win_row_q;
    logic [COL_W-1:0]             win_col_q;
    logic [PIX_W-1:0]             lb_old_rd, lb_new_rd;
    logic                         pop, emit, hs, last_hs;

    // A pop is allowed only if the slot for a possible new window is free
    // or being drained this very edge, and never beyond the frame size.
    assign pop = (state_q == RUN)
              && (wif.fifo_count != 4'd0)
              && (!win_valid_q || wif.out_ready)
              && (pix_cnt_q < CNT_W'(NPIX));

    assign emit    = pop && (y_q >= ROW_W'(2)) && (x_q >= COL_W'(2));
    assign hs      = win_valid_q && wif.out_ready;
    assign last_hs = hs && (win_row_q == ROW_W'(IMG_H - 3))
                        && (win_col_q == COL_W'(IMG_W - 3));

    // lb_old holds row y-2, lb_new holds row y-1; both shift down by one row
    // as each new pixel lands in its column.
    line_buffer #(.DEPTH(IMG_W)) u_lb_old (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (pop),
        .idx_i   (x_q),
        .wdat_i  (lb_new_rd),
        .rdat_o  (lb_old_rd)
    );

    line_buffer #(.DEPTH(IMG_W)) u_lb_new (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (pop),
        .idx_i   (x_q),
        .wdat_i  (wif.fifo_data),
        .rdat_o  (lb_new_rd)
    );

    // Window moves one column left; the incoming column is top..bottom
    // = {row y-2, row y-1, current pixel}. Columns left over from the
    // previous row are pushed out before x reaches 2, so they never appear.
    always_comb begin
        win_shift = win_q;
        for (int r = 0; r < WIN_K; r++) begin
            for (int c = 0; c < WIN_K - 1; c++) begin
                win_shift[WIN_K*r + c] = win_q[WIN_K*r + c + 1];
            end
        end
        win_shift[WIN_K*0 + WIN_K - 1] = lb_old_rd;
        win_shift[WIN_K*1 + WIN_K - 1] = lb_new_rd;
        win_shift[WIN_K*2 + WIN_K - 1] = wif.fifo_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = RUN;
            RUN:     if (last_hs) state_d = DONE;
            DONE:                 state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                pix_cnt_q <= '0;
                x_q       <= '0;
                y_q       <= '0;
            end else if (pop) begin
                pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                win_q     <= win_shift;
                if (x_q == COL_W'(IMG_W - 1)) begin
                    x_q <= '0;
                    y_q <= y_q + ROW_W'(1);
                end else begin
                    x_q <= x_q + COL_W'(1);
                end
            end

            // A new window overwrites one being accepted at the same edge.
            if (emit) begin
                win_valid_q <= 1'b1;
                win_row_q   <= y_q - ROW_W'(2);
                win_col_q   <= x_q - COL_W'(2);
            end else if (hs) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign wif.fifo_pop  = pop;
    assign wif.win_valid = win_valid_q;
    assign wif.win_data  = win_q;
    assign wif.win_row   = win_row_q;
    assign wif.win_col   = win_col_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);

endmodule

// File: doc/input_window_gen.md
# input_window_gen

Downstream consumer of the input-layer pixel FIFO: pops 24-bit pixels (8-bit R,G,B) in raster order and builds a sliding 3x3 window over an IMG_W x IMG_H frame. Emits one 216-bit window per valid (unpadded) position to the first convolution stage over a valid/ready handshake. Two internal line buffers hold the previous rows; the FIFO is popped only when a pixel is available and the output is not stalled.

## Interface
- IMG_W, 8, frame width in pixels (>= 3)
- IMG_H, 8, frame height in pixels (>= 3)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame (honoured only in IDLE)
- fifo_data  in  24  FIFO head pixel, first-word fall-through, valid when fifo_count != 0
- fifo_count  in  4  number of 24-bit pixels available in the FIFO
- fifo_pop  out  1  consume head pixel at this rising edge
- win_valid  out  1  win_data holds a window
- out_ready  in  1  downstream accepts the window this cycle
- win_data  out  216  3x3 window; element k = 3*r + c (r=0 top, c=0 left) at bits [24k+23:24k]
- win_row  out  $clog2(IMG_H)  top-left row of the window
- win_col  out  $clog2(IMG_W)  top-left column of the window
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE -> RUN on start; RUN -> DONE when the last window (row IMG_H-3, col IMG_W-3) is handshaken; DONE -> IDLE after one cycle (done=1 only in DONE).
- fifo_pop = (state==RUN) && (fifo_count != 0) && (!win_valid || out_ready) && (pixels_popped < IMG_W*IMG_H). Combinational.
- On accepted pixel at (y,x): shift 3x3 register left; new right column = {lb_old[x], lb_new[x], fifo_data} (top..bottom); lb_old[x] <= lb_new[x]; lb_new[x] <= fifo_data. Advance x, wrap to 0 and increment y at IMG_W-1.
- At column wrap, window register columns are not cleared; windows are only emitted for x >= 2, so stale columns never appear.
- Window emitted when accepted pixel has y >= 2 and x >= 2: win_valid <= 1, win_row <= y-2, win_col <= x-2.
- If win_valid && out_ready and no new window this edge: win_valid <= 0. If both: new window replaces old (no bubble).
- While win_valid && !out_ready: win_data, win_row, win_col held; no pops.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Pixels per frame: IMG_W*IMG_H exactly; no extra pops.
- start outside IDLE ignored. Counters reset to 0 on entry to RUN.
- Reset (any time, incl. mid-frame): state IDLE; fifo_pop, win_valid, busy, done, win_row, win_col, win_data all 0; line buffers and counters cleared.

## Timing
- win_valid rises the cycle after the edge that popped the window's bottom-right pixel (1-cycle latency).
- Throughput: one pixel per cycle with fifo_count != 0 and no backpressure.
- done rises the cycle after the final window handshake; busy falls the same cycle.
- First pop no earlier than the cycle after start.

## Structure
- Shared package input_layer_pkg: PIX_W=24, WIN_K=3, WIN_W=PIX_W*WIN_K*WIN_K, state enum {IDLE, RUN, DONE}.
- One sub-module: line_buffer (IMG_W x PIX_W shift-style array, write enable, read index); instantiated twice.

## Test plan
- Reset: hold reset_n=0 with random inputs -> all outputs 0; release, no start -> fifo_pop stays 0.
- Nominal IMG_W=IMG_H=4, pixels 0..15 (value = index), fifo_count=4, out_ready=1 -> exactly 4 windows; first {0,1,2,4,5,6,8,9,10} at (0,0), last {5,6,7,9,10,11,13,14,15} at (1,1); 16 pops; done one cycle after last handshake.
- FIFO starvation: same frame, fifo_count=0 for 3 cycles after every 2nd pixel -> fifo_pop 0 during gaps; window sequence identical to nominal.
- Backpressure: out_ready=0 for 5 cycles at first window -> win_data/win_row/win_col stable, fifo_pop 0; release -> remaining windows correct, no loss or duplication.
- Reset mid-frame after 7 pops -> outputs 0 next cycle; new start with fresh 0..15 frame -> nominal result.
- start pulsed during RUN -> ignored; frame completes with 4 windows and a single done pulse.
